// File: rtl/regs_arbiter.sv
// rtl/regs_arbiter.sv - zero-fill and round-robin arbiter in front of a 32 x n register file
module regs_arbiter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [1:0]   req,
  input  logic [1:0]   we,
  input  logic [4:0]   raddr1_0,
  input  logic [4:0]   raddr2_0,
  input  logic [4:0]   raddr1_1,
  input  logic [4:0]   raddr2_1,
  input  logic [n-1:0] wdata_0,
  input  logic [n-1:0] wdata_1,
  output logic [1:0]   gnt,
  output logic [1:0]   rvalid,
  output logic [n-1:0] rdata1_0,
  output logic [n-1:0] rdata2_0,
  output logic [n-1:0] rdata1_1,
  output logic [n-1:0] rdata2_1,
  output logic         init_done,
  output logic         rf_w,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  output logic [n-1:0] rf_wdata,
  input  logic [n-1:0] rf_rdata1,
  input  logic [n-1:0] rf_rdata2
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [4:0] fill_cnt;
  // 1 when requester 1 holds the most recent grant; requester 0 then wins a tie
  logic       last_gnt1;

  // Next state, grant selection and register file port steering
  always_comb begin
    state_n   = state;
    gnt       = 2'b00;
    rf_w      = 1'b0;
    rf_raddr1 = 5'd0;
    rf_raddr2 = 5'd0;
    rf_wdata  = '0;
    case (state)
      ST_INIT: begin
        rf_w      = 1'b1;
        rf_raddr2 = fill_cnt;
        if (fill_cnt == 5'd31) begin
          state_n = ST_ARB;
        end
      end
      ST_ARB: begin
        if (req == 2'b11) begin
          gnt = last_gnt1 ? 2'b01 : 2'b10;
        end else begin
          gnt = req;
        end
        if (gnt[0]) begin
          rf_raddr1 = raddr1_0;
          rf_raddr2 = raddr2_0;
          rf_wdata  = wdata_0;
          rf_w      = we[0] && (raddr2_0 != 5'd0);
        end else if (gnt[1]) begin
          rf_raddr1 = raddr1_1;
          rf_raddr2 = raddr2_1;
          rf_wdata  = wdata_1;
          rf_w      = we[1] && (raddr2_1 != 5'd0);
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // State, fill counter, round-robin pointer and registered read return
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state     <= ST_INIT;
      fill_cnt  <= 5'd1;
      last_gnt1 <= 1'b1;
      init_done <= 1'b0;
      rvalid    <= 2'b00;
      rdata1_0  <= '0;
      rdata2_0  <= '0;
      rdata1_1  <= '0;
      rdata2_1  <= '0;
    end else begin
      state     <= state_n;
      init_done <= (state_n == ST_ARB);
      rvalid    <= gnt;
      if (state == ST_INIT) begin
        fill_cnt <= fill_cnt + 5'd1;
      end
      if (gnt != 2'b00) begin
        last_gnt1 <= gnt[1];
      end
      if (gnt[0]) begin
        rdata1_0 <= rf_rdata1;
        rdata2_0 <= rf_rdata2;
      end
      if (gnt[1]) begin
        rdata1_1 <= rf_rdata1;
        rdata2_1 <= rf_rdata2;
      end
    end
  end

endmodule

// File: doc/regs_arbiter.md
Name: regs_arbiter

Overview:
- Controller for the 32 x n register file (2 combinational read ports, 1 write port, write destination = Raddr2, %0 reads as zero).
- After reset it runs a zero-fill sequence over %1..%31, then shares the file between two requesters (req0 = core, req1 = debug/loader) with round-robin arbitration.
- Read data is returned registered, one cycle after grant.
- Sits between the requesters and the register file; the register file itself is unchanged.

Parameters:
- n, 8, data bus width; matches the register file.

Ports:
- clk  in  1  clock, rising edge.
- nReset  in  1  synchronous, active-low reset.
- req  in  2  request per requester; bit i = requester i.
- we  in  2  write enable per requester; sampled with req.
- raddr1_0, raddr2_0  in  5 each  requester 0 read addresses; raddr2_0 is also the write destination.
- raddr1_1, raddr2_1  in  5 each  requester 1 read addresses; raddr2_1 is also the write destination.
- wdata_0, wdata_1  in  n each  write data.
- gnt  out  2  one-hot grant, combinational.
- rvalid  out  2  registered read-data valid per requester.
- rdata1_0, rdata2_0, rdata1_1, rdata2_1  out  n each  registered read data.
- init_done  out  1  high once the zero-fill is complete.
- rf_w  out  1  register file write control.
- rf_raddr1, rf_raddr2  out  5 each  register file addresses.
- rf_wdata  out  n  register file write data.
- rf_rdata1, rf_rdata2  in  n each  register file read data.

Behaviour:
- Reset (nReset = 0 at a rising edge):
  - State goes to INIT; fill counter = 1.
  - rvalid = 0, all rdata = 0, init_done = 0.
  - Round-robin pointer set so requester 0 wins the first contention.
- Reset mid-operation aborts any access. The grant cycle is lost and no rvalid follows. The zero-fill restarts from %1.
- INIT state:
  - rf_w = 1, rf_raddr2 = counter, rf_wdata = 0, rf_raddr1 = 0, gnt = 0.
  - Counter runs 1..31, one write per cycle (31 cycles).
  - On the write of %31 the state moves to ARB; init_done = 1 from the following cycle.
  - req is ignored in INIT.
- ARB state, per cycle:
  - No request: gnt = 0, rf_w = 0, rf_raddr1 = rf_raddr2 = 0.
  - One request: that requester is granted in the same cycle.
  - Both requesting: grant goes to the requester not granted most recently. The pointer updates only on an actual grant.
  - Granted requester i: rf_raddr1 = raddr1_i, rf_raddr2 = raddr2_i, rf_wdata = wdata_i, rf_w = we[i] AND (raddr2_i != 0). A write to %0 is dropped but still granted.
  - The register file write happens on the clock edge ending the grant cycle.
  - Read data in a write cycle is the pre-write value.
  - rdata1_i / rdata2_i capture rf_rdata1 / rf_rdata2 at the end of the grant cycle. rvalid[i] pulses high for exactly the next cycle.
  - rdata holds its value when rvalid = 0.
- Handshake rules:
  - A requester not granted must hold req and all of its fields stable until granted.
  - req may be dropped only in the cycle after gnt.
  - Back-to-back grants to the same requester are allowed when the other requester is idle; rvalid is then high on consecutive cycles.
- gnt is never 2'b11. gnt = 0 whenever init_done = 0.

Test Plan:
- Reset, then idle 32 cycles:
  - rf_w high exactly 31 cycles with rf_raddr2 = 1..31 and rf_wdata = 0.
  - init_done rises on cycle 32.
  - gnt stays 0 throughout even with req = 2'b11 asserted.
- After init, requester 0 writes 8'hA5 to %3, then reads raddr1_0 = 3:
  - gnt = 2'b01 both times.
  - Read cycle's rvalid[0] is followed by rdata1_0 = 8'hA5.
- req = 2'b11 held for 4 cycles, both doing reads:
  - Grants alternate 01, 10, 01, 10.
  - rvalid follows each grant by one cycle.
- Requester 1 writes 8'hFF to %0, then reads %0:
  - rf_w = 0 during the write grant.
  - Read returns rdata2_1 = 0.
- Requester 0 writes 8'h3C to %5 and reads raddr1_0 = 5 in the same request:
  - rdata1_0 = 0 (pre-write value).
  - A following read returns 8'h3C.
- nReset low for one cycle in the middle of a grant:
  - No rvalid follows.
  - init_done drops, INIT restarts at %1.
  - A previously written %3 reads 0 after the new init completes.
